// File: rtl/memtest_pkg.sv
// Shared definitions for the SRAM memory-test monitor: FSM encoding,
// status digit codes and the blank 7-segment pattern.
package memtest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [3:0] STATUS_IDLE = 4'h0;
  localparam logic [3:0] STATUS_RUN  = 4'h1;
  localparam logic [3:0] STATUS_PASS = 4'hC;
  localparam logic [3:0] STATUS_FAIL = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [5:0] CNT_MAX   = 6'h3F;

  function automatic logic [3:0] status_code(input state_t s);
    case (s)
      ST_IDLE: status_code = STATUS_IDLE;
      ST_RUN:  status_code = STATUS_RUN;
      ST_PASS: status_code = STATUS_PASS;
      default: status_code = STATUS_FAIL;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern; seg[0]=a ... seg[6]=g.
module hex_to_seg7 (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/memtest_monitor.sv
// Passive observer of the SRAM memory tester: counts strobes, captures the last read,
// freezes on pass/fail and shows status on a 4-digit display. Optional MEMMON_BLINK_EN blinks FAIL.
module memtest_monitor
  import memtest_pkg::*;
#(
  parameter int SCAN_BITS  = 16,
  parameter int BLINK_BITS = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] addr,
  input  logic [3:0] data,
  input  logic       wbar,
  input  logic       gbar,
  input  logic       success,
  input  logic       failure,
  output logic [5:0] wr_count,
  output logic [5:0] rd_count,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  logic [3:0] s1_addr, s1_data;
  logic       s1_wbar, s1_gbar, s1_success, s1_failure;
  logic       s2_wbar, s2_gbar;

  // Strobe lines reset to their idle-high level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_addr    <= 4'h0;
      s1_data    <= 4'h0;
      s1_wbar    <= 1'b1;
      s1_gbar    <= 1'b1;
      s1_success <= 1'b0;
      s1_failure <= 1'b0;
      s2_wbar    <= 1'b1;
      s2_gbar    <= 1'b1;
    end else begin
      s1_addr    <= addr;
      s1_data    <= data;
      s1_wbar    <= wbar;
      s1_gbar    <= gbar;
      s1_success <= success;
      s1_failure <= failure;
      s2_wbar    <= s1_wbar;
      s2_gbar    <= s1_gbar;
    end
  end

  logic wr_strobe, rd_strobe;
  assign wr_strobe = s1_wbar & ~s2_wbar;
  assign rd_strobe = s1_gbar & ~s2_gbar;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (s1_failure)                  state_next = ST_FAIL;
        else if (s1_success)             state_next = ST_PASS;
        else if (wr_strobe || rd_strobe) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (s1_failure)      state_next = ST_FAIL;
        else if (s1_success) state_next = ST_PASS;
      end
      default: state_next = state;
    endcase
  end

  logic active, fail_entry;
  assign active     = (state == ST_IDLE) || (state == ST_RUN);
  assign fail_entry = (state_next == ST_FAIL) && (state != ST_FAIL);

  logic [3:0] samp_addr, samp_data, cap_addr, cap_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count  <= 6'd0;
      rd_count  <= 6'd0;
      samp_addr <= 4'h0;
      samp_data <= 4'h0;
      cap_addr  <= 4'h0;
      cap_data  <= 4'h0;
    end else if (active) begin
      if (wr_strobe && wr_count != CNT_MAX) wr_count <= wr_count + 6'd1;
      if (rd_strobe && rd_count != CNT_MAX) rd_count <= rd_count + 6'd1;
      if (!s1_gbar) begin
        samp_addr <= s1_addr;
        samp_data <= s1_data;
      end
      // Entering FAIL pins the capture to the read that was on the bus when it failed.
      if (fail_entry || rd_strobe) begin
        cap_addr <= samp_addr;
        cap_data <= samp_data;
      end
    end
  end

  logic [SCAN_BITS-1:0] scan;
  logic [1:0]           sel;
  logic                 rst_q;

  always_ff @(posedge clk) begin
    if (reset) scan <= '0;
    else       scan <= scan + 1'b1;
  end

  always_ff @(posedge clk) rst_q <= reset;

  assign sel = scan[SCAN_BITS-1 -: 2];

  logic [3:0] digit;
  logic [6:0] seg_dec;
  logic [3:0] an_next;
  logic       dp_next;

  always_comb begin
    digit = rd_count[3:0];
    case (sel)
      2'd3:    digit = status_code(state);
      2'd2:    digit = cap_addr;
      2'd1:    digit = cap_data;
      default: digit = rd_count[3:0];
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex (digit),
    .seg (seg_dec)
  );

`ifdef MEMMON_BLINK_EN
  logic [BLINK_BITS-1:0] blink;

  always_ff @(posedge clk) begin
    if (reset) blink <= '0;
    else       blink <= blink + 1'b1;
  end
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_BITS > 0);
`endif

  always_comb begin
    an_next      = 4'hF;
    an_next[sel] = 1'b0;
`ifdef MEMMON_BLINK_EN
    if (state == ST_FAIL && blink[BLINK_BITS-1]) an_next = 4'hF;
`endif
    dp_next = !((sel == 2'd3) && (state == ST_RUN));
  end

  // seg/an/dp share one register stage; blank through reset and the cycle after.
  always_ff @(posedge clk) begin
    if (reset || rst_q) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_dec;
      an  <= an_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_memtest_monitor.sv
// Self-checking bench for memtest_monitor: vector table of reads, hand-written
// fail/pass/reset sequences, display expectations checked from a queue.
module tb_memtest_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] addr, data;
  logic       wbar, gbar, success, failure;
  logic [5:0] wr_count, rd_count;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // entry = {dp, digit[1:0], nibble[3:0]}
  logic [6:0] exp_q[$];

  typedef struct {
    logic [3:0] addr;
    logic [3:0] data;
    int         len;
    logic [5:0] exp_rd;
  } rd_vec_t;

  rd_vec_t rtab[3];

  memtest_monitor #(.SCAN_BITS(4), .BLINK_BITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data     (data),
    .wbar     (wbar),
    .gbar     (gbar),
    .success  (success),
    .failure  (failure),
    .wr_count (wr_count),
    .rd_count (rd_count),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] d, input int len, input int gap);
    addr = a; data = d; wbar = 1'b0;
    cyc(len);
    wbar = 1'b1;
    cyc(gap);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] d, input int len, input int gap);
    addr = a; data = d; gbar = 1'b0;
    cyc(len);
    gbar = 1'b1;
    cyc(gap);
  endtask

  task automatic chk_counts(input string tag, input logic [5:0] ew, input logic [5:0] er);
    @(negedge clk);
    check({tag, " wr_count"}, wr_count, ew);
    check({tag, " rd_count"}, rd_count, er);
  endtask

  task automatic expect_disp(input logic [1:0] d, input logic [3:0] nib, input logic dpv);
    exp_q.push_back({dpv, d, nib});
  endtask

  task automatic expect_all(input logic [3:0] st, input logic [3:0] ca, input logic [3:0] cd,
                            input logic [5:0] rd, input logic run);
    expect_disp(2'd3, st, !run);
    expect_disp(2'd2, ca, 1'b1);
    expect_disp(2'd1, cd, 1'b1);
    expect_disp(2'd0, rd[3:0], 1'b1);
  endtask

  task automatic drain_display(input string tag);
    logic [6:0] e;
    bit seen;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
        @(negedge clk);
        if (an == ~(4'b0001 << e[5:4])) seen = 1'b1;
      end
      check($sformatf("%s digit%0d lit", tag, e[5:4]), {31'd0, seen}, 32'd1);
      check($sformatf("%s digit%0d seg", tag, e[5:4]), seg, seg_of(e[3:0]));
      check($sformatf("%s digit%0d dp", tag, e[5:4]), dp, e[6]);
    end
    cyc(1);
  endtask

  initial begin
    logic [5:0] m_wr, m_rd;
    logic [3:0] la, ld;
    int blanks;

    rtab[0] = '{addr: 4'h5, data: 4'hA, len: 8, exp_rd: 6'd1};
    rtab[1] = '{addr: 4'hC, data: 4'h3, len: 1, exp_rd: 6'd2};
    rtab[2] = '{addr: 4'hF, data: 4'h0, len: 3, exp_rd: 6'd3};

    reset = 1'b1; addr = 4'h0; data = 4'h0;
    wbar = 1'b1; gbar = 1'b1; success = 1'b0; failure = 1'b0;
    cyc(3);
    reset = 1'b0;

    // Idle after reset
    cyc(1000);
    chk_counts("idle", 6'd0, 6'd0);
    expect_all(4'h0, 4'h0, 4'h0, 6'd0, 1'b0);
    drain_display("idle");

    // 16 writes
    for (int i = 0; i < 16; i++) do_write(i[3:0], ~i[3:0], 4, 3);
    chk_counts("writes", 6'd16, 6'd0);
    expect_all(4'h1, 4'h0, 4'h0, 6'd0, 1'b1);
    drain_display("writes");

    // Table of reads while running
    for (int i = 0; i < 3; i++) begin
      do_read(rtab[i].addr, rtab[i].data, rtab[i].len, 3);
      chk_counts($sformatf("read%0d", i), 6'd16, rtab[i].exp_rd);
      expect_all(4'h1, rtab[i].addr, rtab[i].data, rtab[i].exp_rd, 1'b1);
      drain_display($sformatf("read%0d", i));
    end

    // Failure after a completed read, then frozen
    do_read(4'h9, 4'h3, 4, 3);
    failure = 1'b1;
    cyc(3);
    chk_counts("fail", 6'd16, 6'd4);
    expect_all(4'hF, 4'h9, 4'h3, 6'd4, 1'b0);
    drain_display("fail");
    do_read(4'h2, 4'h6, 4, 3);
    do_write(4'h1, 4'h1, 4, 3);
    chk_counts("frozen", 6'd16, 6'd4);
    expect_all(4'hF, 4'h9, 4'h3, 6'd4, 1'b0);
    drain_display("frozen");

    blanks = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (an == 4'hF) blanks++;
    end
`ifdef MEMMON_BLINK_EN
    check("fail blink blank cycles", blanks, 16);
`else
    check("fail steady blank cycles", blanks, 0);
`endif
    cyc(1);
    failure = 1'b0;

    // Failure raised mid-read: capture taken from the in-flight read
    do_reset();
    addr = 4'hB; data = 4'hE; gbar = 1'b0;
    cyc(2);
    failure = 1'b1;
    cyc(4);
    gbar = 1'b1;
    cyc(3);
    chk_counts("midread fail", 6'd0, 6'd0);
    expect_all(4'hF, 4'hB, 4'hE, 6'd0, 1'b0);
    drain_display("midread fail");
    failure = 1'b0;

    // Saturation, then PASS
    do_reset();
    m_wr = 6'd0; m_rd = 6'd0; la = 4'h0; ld = 4'h0;
    for (int i = 0; i < 70; i++) begin
      do_write(4'h0, 4'h0, 1, 1);
      m_wr = (m_wr == 6'h3F) ? m_wr : m_wr + 6'd1;
    end
    for (int i = 0; i < 70; i++) begin
      la = 4'($urandom_range(0, 15));
      ld = 4'($urandom_range(0, 15));
      do_read(la, ld, 1, 1);
      m_rd = (m_rd == 6'h3F) ? m_rd : m_rd + 6'd1;
    end
    cyc(3);
    chk_counts("saturate", m_wr, m_rd);
    expect_all(4'h1, la, ld, m_rd, 1'b1);
    drain_display("saturate");
    success = 1'b1;
    cyc(3);
    expect_all(4'hC, la, ld, m_rd, 1'b0);
    drain_display("pass");
    failure = 1'b1;
    do_read(~la, ~ld, 2, 3);
    expect_all(4'hC, la, ld, m_rd, 1'b0);
    drain_display("pass sticky");
    success = 1'b0; failure = 1'b0;

    // Both flags from IDLE: FAIL wins
    do_reset();
    success = 1'b1; failure = 1'b1;
    cyc(3);
    expect_disp(2'd3, 4'hF, 1'b1);
    drain_display("both flags");
    success = 1'b0; failure = 1'b0;

    // IDLE straight to PASS
    do_reset();
    success = 1'b1;
    cyc(3);
    expect_disp(2'd3, 4'hC, 1'b1);
    drain_display("idle pass");
    success = 1'b0;

    // Reset mid-test
    do_reset();
    for (int i = 0; i < 10; i++) do_write(i[3:0], i[3:0], 2, 2);
    chk_counts("pre-reset", 6'd10, 6'd0);
    cyc(1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst wr_count", wr_count, 6'd0);
    check("rst rd_count", rd_count, 6'd0);
    check("rst an", an, 4'hF);
    check("rst seg", seg, 7'h7F);
    check("rst dp", dp, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst+1 an", an, 4'hF);
    check("rst+1 seg", seg, 7'h7F);
    @(posedge clk);
    @(negedge clk);
    check("rst+2 an", an, 4'b1110);
    cyc(1);
    expect_all(4'h0, 4'h0, 4'h0, 6'd0, 1'b0);
    drain_display("after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
